// File: rtl/decode_stage.sv
// ID stage of the RV32IM pipeline: instruction decode, integer register file with
// write-through bypass, load-use hazard detection and the ID/EX pipeline register.
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic [31:0] npc,
    input  logic        branch_sig,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stallF,
    output logic        stallD,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_val,
    output logic [31:0] ex_rs2_val,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [6:0]  ex_opcode,
    output logic [2:0]  ex_funct3,
    output logic        ex_funct7b5,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_branch,
    output logic        ex_jal,
    output logic        ex_jalr,
    output logic        ex_use_imm,
    output logic        ex_mul,
    output logic        ex_illegal
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RIDX  = 5;
    localparam int unsigned NREGS = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [6:0]      opcode;
    logic [RIDX-1:0] rd;
    logic [RIDX-1:0] rs1;
    logic [RIDX-1:0] rs2;
    logic [2:0]      funct3;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];

    logic            d_reg_write;
    logic            d_mem_read;
    logic            d_mem_write;
    logic            d_branch;
    logic            d_jal;
    logic            d_jalr;
    logic            d_use_imm;
    logic            d_mul;
    logic            d_illegal;
    logic            use_rs1;
    logic            use_rs2;
    logic [XLEN-1:0] d_imm;

    // Opcode decode: controls, immediate format and which source fields are real.
    always_comb begin
        d_reg_write = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_branch    = 1'b0;
        d_jal       = 1'b0;
        d_jalr      = 1'b0;
        d_use_imm   = 1'b0;
        d_mul       = 1'b0;
        d_illegal   = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        d_imm       = '0;
        case (opcode)
            OPC_OP: begin
                d_reg_write = 1'b1;
                d_mul       = ir[25];
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                d_reg_write = 1'b1;
                d_use_imm   = 1'b1;
                d_mem_read  = (opcode == OPC_LOAD);
                d_jalr      = (opcode == OPC_JALR);
                use_rs1     = 1'b1;
                d_imm       = {{20{ir[31]}}, ir[31:20]};
            end
            OPC_STORE: begin
                d_mem_write = 1'b1;
                d_use_imm   = 1'b1;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                d_imm       = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            end
            OPC_BRANCH: begin
                d_branch = 1'b1;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                d_imm    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            end
            OPC_JAL: begin
                d_jal       = 1'b1;
                d_reg_write = 1'b1;
                d_imm       = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                d_use_imm   = 1'b1;
                d_reg_write = 1'b1;
                d_imm       = {ir[31:12], 12'b0};
            end
            default: d_illegal = 1'b1;
        endcase
        if (rd == '0) begin
            d_reg_write = 1'b0;
        end
    end

    // Register file; contents deliberately left unreset.
    logic [XLEN-1:0] rf [NREGS];

    always_ff @(posedge clk) begin
        if (wb_we && (wb_rd != '0)) begin
            rf[wb_rd] <= wb_data;
        end
    end

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    // Same-cycle writeback is forwarded so the operand never sees a stale value.
    assign rs1_val = (rs1 == '0) ? '0 : ((wb_we && (wb_rd == rs1)) ? wb_data : rf[rs1]);
    assign rs2_val = (rs2 == '0) ? '0 : ((wb_we && (wb_rd == rs2)) ? wb_data : rf[rs2]);

    logic in_ok;
    logic hz;
    logic issue;

    assign hz = ex_valid && ex_mem_read && (ex_rd != '0) && in_ok &&
                ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));

    assign stallF = hz && !branch_sig;
    assign stallD = hz && !branch_sig;
    assign issue  = in_ok && !branch_sig && !hz;

    // ID/EX register: reset, wrong-path, hazard and start-up all collapse to a bubble.
    always_ff @(posedge clk) begin
        in_ok <= !reset;
        if (reset || !issue) begin
            ex_valid     <= 1'b0;
            ex_pc        <= RESET_PC;
            ex_rs1_val   <= '0;
            ex_rs2_val   <= '0;
            ex_imm       <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_opcode    <= '0;
            ex_funct3    <= '0;
            ex_funct7b5  <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jal       <= 1'b0;
            ex_jalr      <= 1'b0;
            ex_use_imm   <= 1'b0;
            ex_mul       <= 1'b0;
            ex_illegal   <= 1'b0;
        end else begin
            ex_valid     <= 1'b1;
            ex_pc        <= npc;
            ex_rs1_val   <= rs1_val;
            ex_rs2_val   <= rs2_val;
            ex_imm       <= d_imm;
            ex_rs1       <= rs1;
            ex_rs2       <= rs2;
            ex_rd        <= rd;
            ex_opcode    <= opcode;
            ex_funct3    <= funct3;
            ex_funct7b5  <= ir[30];
            ex_reg_write <= d_reg_write;
            ex_mem_read  <= d_mem_read;
            ex_mem_write <= d_mem_write;
            ex_branch    <= d_branch;
            ex_jal       <= d_jal;
            ex_jalr      <= d_jalr;
            ex_use_imm   <= d_use_imm;
            ex_mul       <= d_mul;
            ex_illegal   <= d_illegal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a cycle model of the ID stage checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_decode_stage;

    localparam logic [31:0] RPC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir, npc;
    logic        branch_sig;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stallF, stallD, ex_valid;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
    logic        ex_jal, ex_jalr, ex_use_imm, ex_mul, ex_illegal;

    decode_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .ir(ir), .npc(npc), .branch_sig(branch_sig),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stallF(stallF), .stallD(stallD), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
        .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_use_imm(ex_use_imm), .ex_mul(ex_mul),
        .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, v1, v2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7b5, rw, mr, mw, br, jal, jalr, ui, mul, ill;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_rf [32];
    exp_t        m_ex;
    logic        m_ok;
    logic        started = 1'b0;
    logic        last_stall = 1'b0;

    function automatic logic [31:0] rf_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_we && wb_rd == r) return wb_data;
        return m_rf[r];
    endfunction

    function automatic exp_t bubble();
        exp_t e = '0;
        e.pc = RPC;
        return e;
    endfunction

    function automatic exp_t decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t e = '0;
        logic [6:0] op = i[6:0];
        e.valid = 1'b1; e.pc = pc; e.op = op; e.f3 = i[14:12]; e.f7b5 = i[30];
        e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
        e.v1 = rf_read(i[19:15]); e.v2 = rf_read(i[24:20]);
        case (op)
            7'h33: begin e.rw = 1; e.mul = i[25]; end
            7'h13: begin e.rw = 1; e.ui = 1; e.imm = 32'($signed(i[31:20])); end
            7'h03: begin e.rw = 1; e.ui = 1; e.mr = 1; e.imm = 32'($signed(i[31:20])); end
            7'h67: begin e.rw = 1; e.ui = 1; e.jalr = 1; e.imm = 32'($signed(i[31:20])); end
            7'h23: begin e.mw = 1; e.ui = 1; e.imm = 32'($signed({i[31:25], i[11:7]})); end
            7'h63: begin e.br = 1; e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2; end
            7'h6F: begin e.jal = 1; e.rw = 1;
                         e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2; end
            7'h37, 7'h17: begin e.rw = 1; e.ui = 1; e.imm = i & 32'hFFFF_F000; end
            default: e.ill = 1;
        endcase
        if (e.rd == 5'd0) e.rw = 0;
        return e;
    endfunction

    // Load in ID/EX whose destination is a source the current instruction really reads.
    function automatic logic model_hz();
        logic [6:0] op = ir[6:0];
        logic u1 = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
        logic u2 = op inside {7'h33, 7'h23, 7'h63};
        if (!(m_ex.valid && m_ex.mr && m_ex.rd != 0 && m_ok)) return 1'b0;
        return (u1 && ir[19:15] == m_ex.rd) || (u2 && ir[24:20] == m_ex.rd);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic step();
        exp_t act, nxt;
        logic es;
        #1;
        es = model_hz() && !branch_sig;
        if (started) begin
            n_checks++;
            if ({stallF, stallD} !== {es, es}) begin
                n_fail++;
                $display("FAIL stall got=%b%b exp=%b", stallF, stallD, es);
            end
        end
        last_stall = es;
        @(posedge clk);
        if (reset || branch_sig || model_hz() || !m_ok) nxt = bubble();
        else nxt = decode(ir, npc);
        if (wb_we && wb_rd != 0) m_rf[wb_rd] = wb_data;
        m_ex = nxt;
        m_ok = !reset;
        started = 1'b1;
        #1;
        act = '{valid: ex_valid, pc: ex_pc, v1: ex_rs1_val, v2: ex_rs2_val, imm: ex_imm,
                rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd, op: ex_opcode, f3: ex_funct3,
                f7b5: ex_funct7b5, rw: ex_reg_write, mr: ex_mem_read, mw: ex_mem_write,
                br: ex_branch, jal: ex_jal, jalr: ex_jalr, ui: ex_use_imm, mul: ex_mul,
                ill: ex_illegal};
        n_checks++;
        if (act !== m_ex) begin
            n_fail++;
            $display("FAIL idex got=%h exp=%h", act, m_ex);
        end
    endtask

    logic [31:0] tbl [11] = '{32'h0000A103, 32'h0020A423, 32'h0000A103, 32'h12345137,
                              32'h008000EF, 32'h00008067, 32'h02310433, 32'h00001497,
                              32'h40208533, 32'h00412183, 32'h00018463};

    initial begin
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_ex = bubble(); m_ok = 1'b0;
        reset = 1'b1; ir = 32'h0; npc = 32'h0; branch_sig = 1'b0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;

        // Preload the register file while held in reset.
        for (int i = 1; i < 32; i++) begin
            wb_we = 1'b1; wb_rd = 5'(i); wb_data = 32'h1111_0000 + 32'(i);
            step();
        end
        wb_we = 1'b0;
        step();
        chk("rst_pc", ex_pc, RPC);
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_stall", 32'(stallF), 32'd0);

        // Reset then addi x1,x0,5
        reset = 1'b0; ir = 32'h00500093; npc = 32'h8000;
        step();
        chk("startup_bubble", 32'(ex_valid), 32'd0);
        step();
        chk("addi_valid", 32'(ex_valid), 32'd1);
        chk("addi_rd", 32'(ex_rd), 32'd1);
        chk("addi_imm", ex_imm, 32'd5);
        chk("addi_useimm", 32'(ex_use_imm), 32'd1);
        chk("addi_rw", 32'(ex_reg_write), 32'd1);
        chk("addi_pc", ex_pc, 32'h8000);

        // Load-use
        ir = 32'h0000A103; npc = 32'h8004;
        step();
        chk("lw_mr", 32'(ex_mem_read), 32'd1);
        chk("lw_v1", ex_rs1_val, 32'h1111_0001);
        ir = 32'h001101B3; npc = 32'h8008;
        #1 chk("lu_stall", 32'(stallF), 32'd1);
        step();
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        #1 chk("lu_stall_drop", 32'(stallD), 32'd0);
        step();
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_rs1", 32'(ex_rs1), 32'd2);
        chk("add_rs2", 32'(ex_rs2), 32'd1);

        // Writeback bypass
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF; ir = 32'h00028313; npc = 32'h800C;
        step();
        chk("bypass_v1", ex_rs1_val, 32'hDEADBEEF);

        // x0 write / addi x0,x0,1
        wb_rd = 5'd0; wb_data = 32'd7; ir = 32'h00100013; npc = 32'h8010;
        step();
        chk("x0_read", ex_rs1_val, 32'd0);
        chk("x0_rw", 32'(ex_reg_write), 32'd0);
        wb_we = 1'b0;

        // Branch during hazard
        ir = 32'h0000A103; npc = 32'h8014;
        step();
        ir = 32'h001101B3; npc = 32'h8018; branch_sig = 1'b1;
        #1 chk("br_nostall", 32'(stallF), 32'd0);
        step();
        chk("br_bubble", 32'(ex_valid), 32'd0);
        branch_sig = 1'b0; ir = 32'h00308213; npc = 32'h8100;
        step();
        chk("br_next_rd", 32'(ex_rd), 32'd4);
        chk("br_next_imm", ex_imm, 32'd3);

        // Immediates and illegal
        ir = 32'hFE000EE3; npc = 32'h8104;
        step();
        chk("beq_imm", ex_imm, 32'hFFFF_FFFC);
        chk("beq_br", 32'(ex_branch), 32'd1);
        ir = 32'h0000007F; npc = 32'h8108;
        step();
        chk("ill_flag", 32'(ex_illegal), 32'd1);
        chk("ill_valid", 32'(ex_valid), 32'd1);
        chk("ill_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jal,
                             ex_jalr, ex_use_imm, ex_mul}), 32'd0);
        ir = 32'h12345137; npc = 32'h810C;
        step();
        chk("lui_imm", ex_imm, 32'h1234_5000);

        // Mixed stream; fetch holds ir while the model predicts a stall.
        for (int k = 0; k < 11; k++) begin
            ir = tbl[k]; npc = 32'h9000 + 32'(4 * k);
            wb_we = (k % 3 == 0); wb_rd = 5'(k + 1); wb_data = 32'hA5A5_0000 + 32'(k);
            step();
            for (int r = 0; r < 3 && last_stall; r++) begin
                wb_we = 1'b0;
                step();
            end
        end
        wb_we = 1'b0;

        // Reset mid-operation
        reset = 1'b1; ir = 32'h00500093; npc = 32'hA000;
        step();
        reset = 1'b0;
        step();
        chk("rst_mid_bubble", 32'(ex_valid), 32'd0);
        step();
        chk("rst_mid_valid", 32'(ex_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage of the RV32IM core. It consumes `ir`/`npc` from the fetch stage and decodes the instruction. It owns the 32x32 integer register file, with its write port driven by writeback, and registers the decoded operation into the ID/EX pipeline register. It also detects load-use hazards and drives `stallF`/`stallD` back into fetch, and squashes the wrong-path instruction when execute signals a taken branch.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: value of `ex_pc` while in reset or when a bubble is issued.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ir` in 32: instruction from fetch.
- `npc` in 32: PC of `ir`.
- `branch_sig` in 1: taken branch/jump resolved in execute this cycle.
- `wb_we` in 1: writeback enable.
- `wb_rd` in 5: writeback destination register.
- `wb_data` in 32: writeback data.
- `stallF`, `stallD` out 1: hold fetch PC / hold `ir`,`npc` (combinational).
- `ex_valid` out 1: ID/EX holds a real instruction.
- `ex_pc` out 32: PC of the instruction in ID/EX.
- `ex_rs1_val`, `ex_rs2_val` out 32 each: register operand values.
- `ex_imm` out 32: sign-extended immediate.
- `ex_rs1`, `ex_rs2`, `ex_rd` out 5 each: register indices (for forwarding).
- `ex_opcode` out 7; `ex_funct3` out 3; `ex_funct7b5` out 1.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch`, `ex_jal`, `ex_jalr`, `ex_use_imm`, `ex_mul`, `ex_illegal` out 1 each: decoded controls.

## Operation
- **Start-up flag `in_ok`.**
  - Cleared by `reset`; set on the first edge after `reset` deasserts.
  - `ir` is ignored (treated as a bubble) while `in_ok` is 0. This covers the first fetch after reset.
- **Decode (RV32I + M)** by opcode:
  - OP 0110011: R-type. `reg_write`=1. `mul`=`funct7[0]`.
  - OP-IMM 0010011: I-type. `use_imm`=1, `reg_write`=1.
  - LOAD 0000011: I-type. `mem_read`=1, `use_imm`=1, `reg_write`=1.
  - STORE 0100011: S-type. `mem_write`=1, `use_imm`=1.
  - BRANCH 1100011: B-type. `branch`=1.
  - JAL 1101111: J-type. `jal`=1, `reg_write`=1.
  - JALR 1100111: I-type. `jalr`=1, `use_imm`=1, `reg_write`=1.
  - LUI 0110111 and AUIPC 0010111: U-type. `use_imm`=1, `reg_write`=1.
  - Any other opcode: `illegal`=1 with all other controls 0; `ex_valid` is still 1.
- `reg_write` is forced to 0 when `rd`=0.
- **Immediates.** I, S, B, J are sign-extended from `ir[31]`. U is `{ir[31:12],12'b0}`. B and J have bit 0 = 0.
- **Register file.**
  - x0 always reads 0 and is never written.
  - The write happens at the rising edge when `wb_we` is set and `wb_rd`≠0.
  - Reads bypass the write: if `wb_we` and `wb_rd`==rs≠0, the read returns `wb_data` in the same cycle.
  - Contents are not reset.
- **Source usage.**
  - rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - rs2 is used by OP, STORE, BRANCH.
- **Load-use hazard.**
  - `hz` = `ex_valid` & `ex_mem_read` & `ex_rd`≠0 & `in_ok`, and `ex_rd` matches a used rs1 or rs2 of `ir`.
  - `stallF` = `stallD` = `hz` & !`branch_sig`.
- **Priority at each edge (ID/EX update):**
  1. `reset`: all outputs go to their reset values.
  2. `branch_sig`: bubble. The instruction in `ir` is wrong-path.
  3. `hz`: bubble. `ir` is held by fetch and re-decoded next cycle.
  4. `!in_ok`: bubble.
  5. Otherwise: load the decoded instruction with `ex_valid`=1.
- **Bubble contents:** `ex_valid`=0, all controls 0, `ex_rd`/`ex_rs1`/`ex_rs2`=0, `ex_pc`=`RESET_PC`, values and `ex_imm`=0.

## Timing
- **Latency:** `ir` is sampled at edge N and appears on `ex_*` after edge N, one cycle.
- **Reset values:** every `ex_*` output is 0, except `ex_pc`=`RESET_PC`. `in_ok`=0. `stallF`/`stallD` read 0 during reset, because `ex_valid`=0.
- **Reset mid-operation:** ID/EX is cleared on the same edge, and the next edge is again a start-up bubble.
- **Stall duration:** a load-use stall lasts exactly one cycle. After the bubble, `ex_mem_read`=0, so `hz` drops.
- **Branch during hazard:** `branch_sig` with `hz` produces no stall and one bubble.
- **Writeback to a register read in the same cycle:** the bypassed value is captured into `ex_rs*_val`.

## Test plan
- **Reset then addi.** Reset for 2 cycles, release, present `ir`=0x00500093 (addi x1,x0,5) with `npc`=0x8000 for 2 cycles.
  - First edge: bubble.
  - Second edge: `ex_valid`=1, `ex_rd`=1, `ex_imm`=5, `ex_use_imm`=1, `ex_reg_write`=1, `ex_pc`=0x8000.
- **Load-use.** `ir`=0x0000A103 (lw x2,0(x1)), then `ir`=0x001101B3 (add x3,x2,x1).
  - `stallF`=`stallD`=1 for exactly 1 cycle and ID/EX gets a bubble.
  - The add is issued the next cycle with `ex_rs1`=2, `ex_rs2`=1.
- **Writeback bypass.** `wb_we`=1, `wb_rd`=5, `wb_data`=0xDEADBEEF, same cycle as `ir`=0x00028313 (addi x6,x5,0) -> `ex_rs1_val`=0xDEADBEEF.
- **x0 write.** `wb_rd`=0, `wb_data`=7, then read x0 -> 0, and `addi x0,x0,1` gives `ex_reg_write`=0.
- **Branch flush.** `branch_sig`=1 while `hz` is true -> `stallF`=0, bubble in ID/EX. The next `ir` decodes normally.
- **Immediates and illegal.**
  - `ir`=0xFE000EE3 (beq x0,x0,-4) -> `ex_imm`=0xFFFFFFFC, `ex_branch`=1.
  - `ir`=0x0000007F -> `ex_illegal`=1 with all other controls 0.
